// File: rtl/elevator_pkg.sv
// Shared state encoding for the elevator controller and its timing helpers.
package elevator_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE       = 3'd0;
    localparam logic [STATE_W-1:0] ST_FLOOR1     = 3'd1;
    localparam logic [STATE_W-1:0] ST_FLOOR2     = 3'd2;
    localparam logic [STATE_W-1:0] ST_GOING_TO_1 = 3'd3;
    localparam logic [STATE_W-1:0] ST_GOING_TO_2 = 3'd4;

endpackage

// File: rtl/elevator_motion_timer_prescaler.sv
// Divides clk down to a one-cycle decrement strobe every TICK_DIV enabled cycles.
// tick is the combinational wrap indicator; the parent registers it.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    // Counts enabled cycles; clr restarts the period on every timer reload.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
        end
    end

endmodule

// File: rtl/elevator_motion_timer.sv
// Travel / door-dwell countdown for the elevator controller.
// Reloads on every state entry and exposes the new count in the same cycle.
module elevator_motion_timer
    import elevator_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int unsigned TRAVEL_CNT = 5,
    parameter int unsigned DOOR_CNT   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STATE_W-1:0] state,
    output logic [2:0]         counting_value,
    output logic               tick,
    output logic               done_shot,
    output logic               busy
);

    if (TICK_DIV < 1 || TRAVEL_CNT < 1 || TRAVEL_CNT > 7 ||
        DOOR_CNT < 1 || DOOR_CNT > 7) begin : g_param_check
        $fatal(1, "elevator_motion_timer: parameter out of range");
    end

    logic [STATE_W-1:0] prev_state;
    logic [2:0]         count_reg;
    logic [2:0]         load_val;
    logic               change;
    logic               presc_en;
    logic               presc_tick;

    assign change = (state != prev_state);

    // Count loaded on entry to each state; unknown codes behave like idle.
    always_comb begin
        load_val = '0;
        case (state)
            ST_GOING_TO_1, ST_GOING_TO_2: load_val = 3'(TRAVEL_CNT);
            ST_FLOOR1, ST_FLOOR2:         load_val = 3'(DOOR_CNT);
            default:                      load_val = '0;
        endcase
    end

    // Show the new load before it lands so the controller never sees a stale 0.
    assign counting_value = change ? load_val : count_reg;
    assign busy           = (counting_value != '0);
    assign presc_en       = !change && (count_reg != '0);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (change),
        .en   (presc_en),
        .tick (presc_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_state <= ST_IDLE;
            count_reg  <= '0;
            tick       <= 1'b0;
            done_shot  <= 1'b0;
        end else begin
            prev_state <= state;
            tick       <= 1'b0;
            done_shot  <= 1'b0;
            if (change) begin
                count_reg <= load_val;
            end else if (presc_tick) begin
                count_reg <= count_reg - 3'd1;
                tick      <= 1'b1;
                done_shot <= (count_reg == 3'd1);
            end
        end
    end

endmodule

// File: tb/tb_elevator_motion_timer.sv
// Drives a TICK_DIV=4 and a TICK_DIV=1 timer from one stimulus stream and
// compares both against an elapsed-time model of the countdown.
module tb_elevator_motion_timer;
    import elevator_pkg::*;

    localparam int TRAV = 5;
    localparam int DOOR = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] state = 3'd0;

    logic [2:0] cv4, cv1;
    logic       tk4, tk1, dn4, dn1, bz4, bz1;

    int n_chk = 0;
    int n_bad = 0;

    // Model: last seen state, value loaded, cycles elapsed since the load edge.
    int m_prev [2];
    int m_load [2];
    int m_age  [2];
    int m_tick [2];
    int m_done [2];

    always #5 clk = ~clk;

    elevator_motion_timer #(.TICK_DIV(4), .TRAVEL_CNT(TRAV), .DOOR_CNT(DOOR)) u_dut4 (
        .clk(clk), .rst(rst), .state(state),
        .counting_value(cv4), .tick(tk4), .done_shot(dn4), .busy(bz4)
    );

    elevator_motion_timer #(.TICK_DIV(1), .TRAVEL_CNT(TRAV), .DOOR_CNT(DOOR)) u_dut1 (
        .clk(clk), .rst(rst), .state(state),
        .counting_value(cv1), .tick(tk1), .done_shot(dn1), .busy(bz1)
    );

    function automatic int td(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int load_of(int s);
        if (s == 3 || s == 4) return TRAV;
        if (s == 1 || s == 2) return DOOR;
        return 0;
    endfunction

    function automatic int exp_cv(int i);
        int used;
        if (int'(state) != m_prev[i]) return load_of(int'(state));
        used = m_age[i] / td(i);
        if (used > m_load[i]) used = m_load[i];
        return m_load[i] - used;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            m_tick[i] = 0;
            m_done[i] = 0;
            if (rst) begin
                m_prev[i] = 0;
                m_load[i] = 0;
                m_age[i]  = 0;
            end else if (int'(state) != m_prev[i]) begin
                m_prev[i] = int'(state);
                m_load[i] = load_of(int'(state));
                m_age[i]  = 0;
            end else begin
                if (m_age[i] < 1000) m_age[i]++;
                if (m_load[i] != 0 && m_age[i] % td(i) == 0 && m_age[i] / td(i) <= m_load[i]) begin
                    m_tick[i] = 1;
                    m_done[i] = (m_age[i] / td(i) == m_load[i]) ? 1 : 0;
                end
            end
        end
    endtask

    task automatic check_outs(input bit regd);
        string sfx;
        sfx = regd ? "reg" : "comb";
        check($sformatf("cv_td4_%s", sfx), int'(cv4), exp_cv(0));
        check($sformatf("busy_td4_%s", sfx), int'(bz4), (exp_cv(0) != 0) ? 1 : 0);
        check($sformatf("cv_td1_%s", sfx), int'(cv1), exp_cv(1));
        check($sformatf("busy_td1_%s", sfx), int'(bz1), (exp_cv(1) != 0) ? 1 : 0);
        if (regd) begin
            check("tick_td4", int'(tk4), m_tick[0]);
            check("done_td4", int'(dn4), m_done[0]);
            check("tick_td1", int'(tk1), m_tick[1]);
            check("done_td1", int'(dn1), m_done[1]);
        end
    endtask

    // Inputs are set at the negedge before calling; one call is one clock.
    task automatic step();
        #1 check_outs(1'b0);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outs(1'b1);
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_prev[i] = 0; m_load[i] = 0; m_age[i] = 0; m_tick[i] = 0; m_done[i] = 0;
        end
        @(negedge clk);

        // Reset and quiet idle period
        rst = 1'b1; state = 3'd0; hold(3);
        rst = 1'b0; hold(50);
        // Full travel, then door dwell after expiry
        state = ST_GOING_TO_2; hold(30);
        state = ST_FLOOR2;     hold(40);
        // Aborts mid-count to idle and to an invalid code
        state = ST_IDLE;       hold(3);
        state = ST_GOING_TO_2; hold(10);
        state = ST_IDLE;       hold(10);
        state = ST_GOING_TO_2; hold(10);
        state = 3'd7;          hold(10);
        // Reset mid-prescale, then reload on release with state still non-idle
        state = ST_GOING_TO_2; hold(6);
        rst = 1'b1;            hold(1);
        rst = 1'b0;            hold(30);
        // Back-to-back state entries without expiry
        state = ST_GOING_TO_1; hold(2);
        state = ST_FLOOR1;     hold(1);
        state = ST_GOING_TO_2; hold(25);

        for (int seg = 0; seg < 300; seg++) begin
            state = 3'($urandom_range(0, 7));
            hold(int'($urandom_range(1, 30)));
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1; hold(1);
                rst = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
